// File: rtl/regfile_dump_reader_pkg.sv
// rtl/regfile_dump_reader_pkg.sv - shared state encodings and register-file geometry
package regfile_dump_reader_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ADDR_W   = 3;
    localparam int DEF_NUM_REGS = 1 << DEF_ADDR_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_READ = ST_READ,
        S_SEND = ST_SEND,
        S_DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// rtl/regfile_dump_reader_if.sv - output word stream carrying register value and address
interface regfile_dump_reader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [ADDR_W-1:0] m_addr;
    logic              m_last;

    modport master (output m_valid, output m_data, output m_addr, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_addr, input m_last, output m_ready);
endinterface

// File: rtl/regfile_dump_reader_addr_wrap_counter.sv
// rtl/regfile_dump_reader_addr_wrap_counter.sv - loadable address up-counter wrapping modulo NUM_REGS
module addr_wrap_counter #(
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              en,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] cnt
);
    localparam logic [ADDR_W-1:0] TOP = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = (cnt_q == TOP) ? '0 : cnt_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - streams a wrapping range of register-file words with their addresses
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      first_addr,
    input  logic [ADDR_W:0]        count,
    output logic                   busy,
    output logic [ADDR_W-1:0]      rd_addr,
    input  logic [DATA_W-1:0]      rd_data,
    regfile_dump_reader_if.master  m,
    output logic                   done
);
    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     remaining_q, remaining_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic                m_last_q, m_last_d;
    logic                addr_load, addr_en;
    logic [ADDR_W-1:0]   cur_addr;

    addr_wrap_counter #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_addr (
        .clk      (clk),
        .reset    (reset),
        .load     (addr_load),
        .en       (addr_en),
        .load_val (first_addr),
        .cnt      (cur_addr)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        m_data_d    = m_data_q;
        m_addr_d    = m_addr_q;
        m_last_d    = m_last_q;
        addr_load   = 1'b0;
        addr_en     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        state_d = S_DONE;
                    end else begin
                        // Saturate so no register is read twice in one dump.
                        addr_load   = 1'b1;
                        remaining_d = (count > MAX_CNT) ? MAX_CNT : count;
                        state_d     = S_READ;
                    end
                end
            end
            S_READ: begin
                m_data_d = rd_data;
                m_addr_d = cur_addr;
                m_last_d = (remaining_q == ONE);
                state_d  = S_SEND;
            end
            S_SEND: begin
                if (m.m_ready) begin
                    if (remaining_q == ONE) begin
                        state_d = S_DONE;
                    end else begin
                        addr_en     = 1'b1;
                        remaining_d = remaining_q - ONE;
                        state_d     = S_READ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            m_data_q    <= '0;
            m_addr_q    <= '0;
            m_last_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            m_data_q    <= m_data_d;
            m_addr_q    <= m_addr_d;
            m_last_q    <= m_last_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign rd_addr   = cur_addr;
    assign m.m_valid = (state_q == S_SEND);
    assign m.m_data  = m_data_q;
    assign m.m_addr  = m_addr_q;
    assign m.m_last  = m_last_q;
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb/tb_regfile_dump_reader.sv - directed bench for regfile_dump_reader
module tb_regfile_dump_reader;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] first_addr;
    logic [3:0] count;
    logic       busy;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic       done;
    logic [7:0] regs [8];

    int n_checks;
    int n_fail;

    regfile_dump_reader_if #(.DATA_W(8), .ADDR_W(3)) mif ();

    regfile_dump_reader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .first_addr (first_addr),
        .count      (count),
        .busy       (busy),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .m          (mif),
        .done       (done)
    );

    assign rd_data = regs[rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] fa;
        logic [3:0] cnt;
        int         exp_n;
        logic [2:0] exp_last;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input logic [2:0] fa, input logic [3:0] cnt);
        first_addr = fa;
        count      = cnt;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_dump(input logic [2:0] fa, input logic [3:0] cnt,
                            input int exp_n, input logic [2:0] exp_last);
        logic [2:0] a;
        logic [7:0] ed;
        pulse_start(fa, cnt);
        @(negedge clk);
        check("busy_after_start", busy, 1);
        check("valid_after_start", mif.m_valid, 0);
        if (exp_n == 0) begin
            check("done_empty", done, 1);
        end else begin
            check("rd_addr_first", rd_addr, fa);
            check("done_early", done, 0);
            for (int i = 0; i < exp_n; i++) begin
                a  = fa + 3'(i);
                ed = 8'h10 + {5'b0, a};
                @(negedge clk);
                check("word_valid", mif.m_valid, 1);
                check("word_addr", mif.m_addr, a);
                check("word_data", mif.m_data, ed);
                check("word_last", mif.m_last, (i == exp_n - 1));
                if (i == exp_n - 1) check("last_addr", mif.m_addr, exp_last);
                @(negedge clk);
                check("valid_gap", mif.m_valid, 0);
                check("done_pulse", done, (i == exp_n - 1));
            end
        end
        @(negedge clk);
        check("done_end", done, 0);
        check("busy_end", busy, 0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        start       = 1'b0;
        first_addr  = '0;
        count       = '0;
        mif.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) regs[i] = 8'h10 + 8'(i);

        vecs[0] = '{3'd2, 4'd3,  3, 3'd4};
        vecs[1] = '{3'd6, 4'd4,  4, 3'd1};
        vecs[2] = '{3'd5, 4'd12, 8, 3'd4};
        vecs[3] = '{3'd0, 4'd8,  8, 3'd7};
        vecs[4] = '{3'd7, 4'd1,  1, 3'd7};
        vecs[5] = '{3'd3, 4'd0,  0, 3'd0};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", mif.m_valid, 0);
        check("rst_done", done, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_m_data", mif.m_data, 0);
        check("rst_m_addr", mif.m_addr, 0);
        check("rst_m_last", mif.m_last, 0);

        foreach (vecs[k]) run_dump(vecs[k].fa, vecs[k].cnt, vecs[k].exp_n, vecs[k].exp_last);

        // Backpressure on word 2 while the register file changes underneath.
        pulse_start(3'd1, 4'd4);
        @(negedge clk);
        @(negedge clk);
        check("stall_w1_addr", mif.m_addr, 1);
        check("stall_w1_data", mif.m_data, 8'h11);
        @(negedge clk);
        @(negedge clk);
        check("stall_w2_valid", mif.m_valid, 1);
        mif.m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 0) regs[3] = 8'hA3;
            if (k == 1) regs[2] = 8'hE2;
            if (k == 2) begin
                first_addr = 3'd5;
                count      = 4'd2;
                start      = 1'b1;
            end
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            check("stall_valid", mif.m_valid, 1);
            check("stall_addr", mif.m_addr, 2);
            check("stall_data", mif.m_data, 8'h12);
            check("stall_last", mif.m_last, 0);
            check("stall_busy", busy, 1);
        end
        mif.m_ready = 1'b1;
        @(negedge clk);
        check("stall_read_valid", mif.m_valid, 0);
        check("stall_rd_addr", rd_addr, 3);
        @(negedge clk);
        check("stall_w3_addr", mif.m_addr, 3);
        check("stall_w3_data", mif.m_data, 8'hA3);
        @(negedge clk);
        @(negedge clk);
        check("stall_w4_addr", mif.m_addr, 4);
        check("stall_w4_data", mif.m_data, 8'h14);
        check("stall_w4_last", mif.m_last, 1);
        @(negedge clk);
        check("stall_done", done, 1);
        @(negedge clk);
        check("stall_idle_busy", busy, 0);
        check("stall_idle_done", done, 0);
        regs[2] = 8'h12;
        regs[3] = 8'h13;

        // Reset during SEND of word 2 of 4.
        pulse_start(3'd0, 4'd4);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("rs_w2_valid", mif.m_valid, 1);
        check("rs_w2_addr", mif.m_addr, 1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rs_valid", mif.m_valid, 0);
        check("rs_busy", busy, 0);
        check("rs_data", mif.m_data, 0);
        check("rs_addr", mif.m_addr, 0);
        check("rs_rd_addr", rd_addr, 0);
        check("rs_done", done, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rs_no_done", done, 0);
            check("rs_no_valid", mif.m_valid, 0);
        end
        run_dump(3'd0, 4'd4, 4, 3'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Read-side sequencer for the 8×8 register file. On a start pulse it reads a contiguous range of registers through the register file's combinational read port, wrapping at the top of the address space. It streams each value with its address over a valid/ready output. It sits between the register file's read port and any downstream consumer (debug dump, serializer, checksum unit), which is then never driven directly by register-file timing.

## Interface
Parameters:
- DATA_W, 8: register width
- ADDR_W, 3: register address width
- NUM_REGS, 8: number of registers, equal to 2**ADDR_W

Ports:
- clk  in  1  rising-edge clock, sole clock domain
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk
- start  in  1  one-cycle request to begin a dump; honoured only in IDLE
- first_addr  in  ADDR_W  first register to read; sampled with start
- count  in  ADDR_W+1  number of registers to read; sampled with start
- busy  out  1  high in every state except IDLE
- rd_addr  out  ADDR_W  register file read address, registered
- rd_data  in  DATA_W  register file read data, combinational from rd_addr
- m_valid  out  1  output word valid
- m_ready  in  1  consumer accepts the word
- m_data  out  DATA_W  register value
- m_addr  out  ADDR_W  address m_data came from
- m_last  out  1  high with the final word of a dump
- done  out  1  one-cycle pulse after the last word is accepted, or after an empty dump

## Operation
- States: IDLE, READ, SEND, DONE.
- Internal registers:
  - cur_addr, ADDR_W bits; drives rd_addr directly.
  - remaining, ADDR_W+1 bits.
- IDLE:
  - start with count==0: go to DONE. Nothing is emitted.
  - start with count!=0: cur_addr<=first_addr, remaining<=min(count, NUM_REGS), go to READ.
  - Counts above NUM_REGS saturate to NUM_REGS. Each register is read at most once per dump.
- READ: m_data<=rd_data, m_addr<=cur_addr, m_last<=(remaining==1), go to SEND.
- SEND:
  - m_valid=1.
  - m_data, m_addr and m_last stay stable until m_valid&&m_ready.
  - On handshake with remaining==1: go to DONE.
  - On handshake with remaining>1: cur_addr<=cur_addr+1 (mod NUM_REGS, so NUM_REGS-1 wraps to 0), remaining<=remaining-1, go to READ.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- start is ignored in every state except IDLE. It is neither queued nor does it restart the dump.
- Each value is the register content on the clk edge that ends its READ cycle. Concurrent writes to the register file are not blocked.
- Reset: state<=IDLE, cur_addr<=0, remaining<=0, m_data<=0, m_addr<=0, m_last<=0. Outputs busy, m_valid and done are 0.
- A reset during READ or SEND abandons the dump. No done pulse is produced, and m_valid is low on the cycle after reset.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from m_ready or start to any output.
- start at edge T (count≥1): rd_addr=first_addr and busy=1 from T; m_valid=1 from T+1.
- Minimum word period is 2 cycles (READ + SEND). With m_ready held high, an N-word dump occupies 2N cycles from start to the done pulse.
- done is asserted in the cycle after the final handshake. busy drops one cycle after done.
- count==0: done pulses the cycle after start and m_valid never rises.
- m_ready high while m_valid is low has no effect.

## Structure
- A shared header holds the state encodings (2-bit localparams ST_IDLE/ST_READ/ST_SEND/ST_DONE) and the DATA_W/ADDR_W/NUM_REGS defaults, so the register file and its reader stay in agreement.
- One sub-module, addr_wrap_counter: a loadable ADDR_W-bit up-counter with enable, wrapping modulo NUM_REGS and reset synchronously to 0. It implements cur_addr.
- The remaining down-counter and output holding registers live inline in the top module.

## Test plan
- Load register file with reg[i]=8'h10+i; start, first_addr=2, count=3, m_ready=1 -> words (2,8'h12), (3,8'h13), (4,8'h14,m_last=1) at 2-cycle spacing; done 1 cycle after the last handshake.
- first_addr=6, count=4 -> addresses 6,7,0,1 with data 8'h16,8'h17,8'h10,8'h11 (wrap-around).
- count=0 -> done pulses the cycle after start; m_valid stays 0; busy high for 1 cycle.
- count=12, first_addr=5 -> exactly 8 words, addresses 5..7,0..4; m_last on address 4.
- Hold m_ready=0 for 5 cycles mid-dump while writing the next register -> m_data/m_addr stable throughout; the next word carries the newly written value; second start pulses during the dump are ignored.
- Assert reset during SEND of word 2 of 4 -> next cycle m_valid=0, busy=0, m_data=0; no done; a new start then runs a full dump normally.
